// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES round constants, FSM/update encodings and pure round-transform functions
package aes_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam int AES256_ROUNDS = 14;

  localparam logic KEYLEN_128 = 1'b0;
  localparam logic KEYLEN_256 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_SBOX,
    ST_MAIN
  } enc_state_t;

  typedef enum logic [2:0] {
    UPD_NONE,
    UPD_INIT,
    UPD_SBOX,
    UPD_MAIN,
    UPD_FINAL
  } upd_t;

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm3(input logic [7:0] b);
    return gm2(b) ^ b;
  endfunction

  function automatic logic [31:0] mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm2(b0) ^ gm3(b1) ^ b2 ^ b3,
            b0 ^ gm2(b1) ^ gm3(b2) ^ b3,
            b0 ^ b1 ^ gm2(b2) ^ gm3(b3),
            gm3(b0) ^ b1 ^ b2 ^ gm2(b3)};
  endfunction

  function automatic logic [127:0] mixcolumns(input logic [127:0] s);
    return {mixw(s[127:96]), mixw(s[95:64]), mixw(s[63:32]), mixw(s[31:0])};
  endfunction

  // Row r rotates left by r columns: output word i byte r comes from word (i+r) mod 4.
  function automatic logic [127:0] shiftrows(input logic [127:0] s);
    logic [31:0] w0, w1, w2, w3;
    w0 = s[127:96];
    w1 = s[95:64];
    w2 = s[63:32];
    w3 = s[31:0];
    return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
            w1[31:24], w2[23:16], w3[15:8], w0[7:0],
            w2[31:24], w3[23:16], w0[15:8], w1[7:0],
            w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
  endfunction

  function automatic logic [127:0] addroundkey(input logic [127:0] s, input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_encipher_block.sv
// rtl/aes_encipher_block.sv - iterative AES encipher round engine with word-serial shared S-box
module aes_encipher_block
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         next,
  input  logic         keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready
);

  enc_state_t   state, state_next;
  upd_t         upd;
  logic [127:0] state_reg, state_reg_next;
  logic [3:0]   round_ctr, round_ctr_next;
  logic [1:0]   sword_ctr, sword_ctr_next;
  logic         ready_reg, ready_next;
  logic         keylen_reg, keylen_next;
  logic [3:0]   num_rounds;

  // Keylen is latched at acceptance so mid-run changes cannot alter the round count.
  assign num_rounds = (keylen_reg == KEYLEN_256) ? 4'(AES256_ROUNDS) : 4'(AES128_ROUNDS);

  assign round     = round_ctr;
  assign new_block = state_reg;
  assign ready     = ready_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      state_reg  <= '0;
      round_ctr  <= '0;
      sword_ctr  <= '0;
      ready_reg  <= 1'b1;
      keylen_reg <= KEYLEN_128;
    end else begin
      state      <= state_next;
      state_reg  <= state_reg_next;
      round_ctr  <= round_ctr_next;
      sword_ctr  <= sword_ctr_next;
      ready_reg  <= ready_next;
      keylen_reg <= keylen_next;
    end
  end

  always_comb begin
    state_next     = state;
    upd            = UPD_NONE;
    round_ctr_next = round_ctr;
    sword_ctr_next = sword_ctr;
    ready_next     = ready_reg;
    keylen_next    = keylen_reg;
    sboxw          = '0;

    case (state)
      ST_IDLE: begin
        if (next) begin
          round_ctr_next = '0;
          ready_next     = 1'b0;
          keylen_next    = keylen;
          state_next     = ST_INIT;
        end
      end
      ST_INIT: begin
        upd            = UPD_INIT;
        round_ctr_next = 4'd1;
        sword_ctr_next = '0;
        state_next     = ST_SBOX;
      end
      ST_SBOX: begin
        upd = UPD_SBOX;
        case (sword_ctr)
          2'd0:    sboxw = state_reg[127:96];
          2'd1:    sboxw = state_reg[95:64];
          2'd2:    sboxw = state_reg[63:32];
          default: sboxw = state_reg[31:0];
        endcase
        sword_ctr_next = sword_ctr + 2'd1;
        if (sword_ctr == 2'd3) state_next = ST_MAIN;
      end
      ST_MAIN: begin
        if (round_ctr < num_rounds) begin
          upd            = UPD_MAIN;
          round_ctr_next = round_ctr + 4'd1;
          sword_ctr_next = '0;
          state_next     = ST_SBOX;
        end else begin
          upd        = UPD_FINAL;
          ready_next = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    state_reg_next = state_reg;
    case (upd)
      UPD_INIT:  state_reg_next = addroundkey(block, round_key);
      UPD_SBOX: begin
        case (sword_ctr)
          2'd0:    state_reg_next = {new_sboxw, state_reg[95:0]};
          2'd1:    state_reg_next = {state_reg[127:96], new_sboxw, state_reg[63:0]};
          2'd2:    state_reg_next = {state_reg[127:64], new_sboxw, state_reg[31:0]};
          default: state_reg_next = {state_reg[127:32], new_sboxw};
        endcase
      end
      UPD_MAIN:  state_reg_next = addroundkey(mixcolumns(shiftrows(state_reg)), round_key);
      UPD_FINAL: state_reg_next = addroundkey(shiftrows(state_reg), round_key);
      default:   state_reg_next = state_reg;
    endcase
  end

endmodule

// File: tb/tb_aes_encipher_block.sv
// tb/tb_aes_encipher_block.sv - directed FIPS-197 vector bench for aes_encipher_block
module tb_aes_encipher_block;

  logic         clk;
  logic         reset_n;
  logic         next;
  logic         keylen;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
  logic [127:0] block;
  logic [127:0] new_block;
  logic         ready;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic [7:0] sbox_tbl [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [127:0] rk [0:14];

  // Shared-S-box and key-memory models served combinationally, as the core would.
  assign new_sboxw = {sbox_tbl[sboxw[31:24]], sbox_tbl[sboxw[23:16]],
                      sbox_tbl[sboxw[15:8]], sbox_tbl[sboxw[7:0]]};
  assign round_key = rk[round];

  aes_encipher_block dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .next      (next),
    .keylen    (keylen),
    .round     (round),
    .round_key (round_key),
    .sboxw     (sboxw),
    .new_sboxw (new_sboxw),
    .block     (block),
    .new_block (new_block),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tbl[w[31:24]], sbox_tbl[w[23:16]], sbox_tbl[w[15:8]], sbox_tbl[w[7:0]]};
  endfunction

  task automatic expand_key(input logic [255:0] key, input logic kl);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    int nw;
    nk = kl ? 8 : 4;
    nw = kl ? 60 : 44;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < nw; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      rk[r] = (4*r+3 < nw) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // Drives one operation; cycles counts edges from the accepting edge (1) until ready is seen.
  task automatic do_op(input logic [127:0] pt, input logic kl,
                       output logic [127:0] ct, output int cycles, output int max_round);
    block  = pt;
    keylen = kl;
    next   = 1'b1;
    @(posedge clk); #1;
    next      = 1'b0;
    cycles    = 1;
    max_round = int'(round);
    while (!ready && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (int'(round) > max_round) max_round = int'(round);
    end
    ct = new_block;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    next    = 1'b0;
    keylen  = 1'b0;
    block   = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (new_block !== 128'h0) begin errors++; $display("FAIL reset_new_block got %h want 0", new_block); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (round !== 4'd0) begin errors++; $display("FAIL reset_round got %0d want 0", round); end
    checks++; if (sboxw !== 32'h0) begin errors++; $display("FAIL reset_sboxw got %h want 0", sboxw); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips_b();
    int cycles;
    expand_key({KEY_B, 128'h0}, 1'b0);
    block  = PT_B;
    keylen = 1'b0;
    next   = 1'b1;
    @(posedge clk); #1;
    next   = 1'b0;
    cycles = 1;
    checks++; if (sboxw !== 32'h0) begin errors++; $display("FAIL b_init_sboxw got %h want 0", sboxw); end
    @(posedge clk); #1; cycles++;
    checks++; if (sboxw !== 32'h193de3be) begin errors++; $display("FAIL b_sbox0_sboxw got %h want 193de3be", sboxw); end
    checks++; if (new_block !== 128'h193de3bea0f4e22b9ac68d2ae9f84808) begin errors++; $display("FAIL b_init_state got %h want 193de3bea0f4e22b9ac68d2ae9f84808", new_block); end
    @(posedge clk); #1; cycles++;
    checks++; if (new_block[127:96] !== 32'hd42711ae) begin errors++; $display("FAIL b_w0_sub got %h want d42711ae", new_block[127:96]); end
    checks++; if (new_block[95:0] !== 96'ha0f4e22b9ac68d2ae9f84808) begin errors++; $display("FAIL b_w123_hold got %h want a0f4e22b9ac68d2ae9f84808", new_block[95:0]); end
    checks++; if (sboxw !== 32'ha0f4e22b) begin errors++; $display("FAIL b_sbox1_sboxw got %h want a0f4e22b", sboxw); end
    repeat (3) begin @(posedge clk); #1; cycles++; end
    checks++; if (sboxw !== 32'h0) begin errors++; $display("FAIL b_main_sboxw got %h want 0", sboxw); end
    checks++; if (new_block !== 128'hd42711aee0bf98f1b8b45de51e415230) begin errors++; $display("FAIL b_subbytes got %h want d42711aee0bf98f1b8b45de51e415230", new_block); end
    while (!ready && cycles < 200) begin @(posedge clk); #1; cycles++; end
    checks++; if (new_block !== CT_B) begin errors++; $display("FAIL b_result got %h want %h", new_block, CT_B); end
    checks++; if (cycles !== 52) begin errors++; $display("FAIL b_latency got %0d want 52", cycles); end
  endtask

  task automatic test_aes128_c1();
    logic [127:0] ct;
    int cycles, maxr;
    expand_key({KEY_C1, 128'h0}, 1'b0);
    do_op(PT_C, 1'b0, ct, cycles, maxr);
    checks++; if (ct !== CT_C1) begin errors++; $display("FAIL c1_result got %h want %h", ct, CT_C1); end
    checks++; if (cycles !== 52) begin errors++; $display("FAIL c1_latency got %0d want 52", cycles); end
  endtask

  task automatic test_aes256_c3();
    logic [127:0] ct;
    int cycles, maxr;
    expand_key(KEY_C3, 1'b1);
    do_op(PT_C, 1'b1, ct, cycles, maxr);
    checks++; if (ct !== CT_C3) begin errors++; $display("FAIL c3_result got %h want %h", ct, CT_C3); end
    checks++; if (cycles !== 72) begin errors++; $display("FAIL c3_latency got %0d want 72", cycles); end
    checks++; if (maxr !== 14) begin errors++; $display("FAIL c3_max_round got %0d want 14", maxr); end
  endtask

  task automatic test_busy();
    int cycles;
    expand_key({KEY_C1, 128'h0}, 1'b0);
    block  = PT_C;
    keylen = 1'b0;
    next   = 1'b1;
    @(posedge clk); #1;
    next   = 1'b0;
    cycles = 1;
    while (!ready && cycles < 200) begin
      if (cycles == 20) begin
        next   = 1'b1;
        keylen = 1'b1;
        block  = ~PT_C;
      end else begin
        next = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
    end
    next   = 1'b0;
    keylen = 1'b0;
    checks++; if (new_block !== CT_C1) begin errors++; $display("FAIL busy_result got %h want %h", new_block, CT_C1); end
    checks++; if (cycles !== 52) begin errors++; $display("FAIL busy_latency got %0d want 52", cycles); end
    @(posedge clk); #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_no_restart got ready %b want 1", ready); end
  endtask

  task automatic test_reset_midop();
    logic [127:0] ct;
    int cycles, maxr;
    expand_key({KEY_C1, 128'h0}, 1'b0);
    block  = PT_C;
    keylen = 1'b0;
    next   = 1'b1;
    @(posedge clk); #1;
    next = 1'b0;
    repeat (29) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    checks++; if (new_block !== 128'h0) begin errors++; $display("FAIL rst_mid_new_block got %h want 0", new_block); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", ready); end
    checks++; if (round !== 4'd0) begin errors++; $display("FAIL rst_mid_round got %0d want 0", round); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    do_op(PT_C, 1'b0, ct, cycles, maxr);
    checks++; if (ct !== CT_C1) begin errors++; $display("FAIL rst_after_result got %h want %h", ct, CT_C1); end
    checks++; if (cycles !== 52) begin errors++; $display("FAIL rst_after_latency got %0d want 52", cycles); end
  endtask

  task automatic test_back_to_back();
    int cycles;
    int hi;
    expand_key({KEY_C1, 128'h0}, 1'b0);
    block  = PT_C;
    keylen = 1'b0;
    next   = 1'b1;
    @(posedge clk); #1;
    cycles = 1;
    while (!ready && cycles < 200) begin @(posedge clk); #1; cycles++; end
    checks++; if (new_block !== CT_C1) begin errors++; $display("FAIL b2b_first got %h want %h", new_block, CT_C1); end
    // Swap key memory and plaintext during the single idle cycle before the second INIT.
    expand_key({KEY_B, 128'h0}, 1'b0);
    block = PT_B;
    hi = 0;
    while (ready && hi < 5) begin hi++; @(posedge clk); #1; end
    checks++; if (hi !== 1) begin errors++; $display("FAIL b2b_ready_gap got %0d want 1", hi); end
    cycles = 1;
    while (!ready && cycles < 200) begin @(posedge clk); #1; cycles++; end
    next = 1'b0;
    checks++; if (new_block !== CT_B) begin errors++; $display("FAIL b2b_second got %h want %h", new_block, CT_B); end
    checks++; if (cycles !== 52) begin errors++; $display("FAIL b2b_second_latency got %0d want 52", cycles); end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int r = 0; r < 15; r++) rk[r] = '0;
    test_reset();
    test_fips_b();
    test_aes128_c1();
    test_aes256_c3();
    test_busy();
    test_reset_midop();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aes_encipher_block.md
Name: aes_encipher_block

Overview:
Iterative AES encipher round engine, the forward-direction counterpart of the decipher datapath in the AES core. It applies the initial AddRoundKey, the main rounds (SubBytes, ShiftRows, MixColumns, AddRoundKey) and the final round (no MixColumns) to one 128-bit block. Round keys come from the shared key memory, indexed by the `round` output. SubBytes processes one 32-bit word per cycle through an external forward S-box that is shared with key expansion.

Parameters:
- None. All constants live in aes_pkg.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- next  in  1  start-encipher pulse; accepted only in IDLE.
- keylen  in  1  0 = AES-128 (10 rounds), 1 = AES-256 (14 rounds).
- round  out  4  current round index presented to the key memory.
- round_key  in  128  round key for `round`; valid in the same cycle (combinational read).
- sboxw  out  32  word sent to the shared forward S-box.
- new_sboxw  in  32  S-box result for sboxw, combinational.
- block  in  128  plaintext; sampled only in INIT.
- new_block  out  128  state register, {w0,w1,w2,w3} with w0 in [127:96].
- ready  out  1  high when idle and the result is valid.

Behaviour:
- Reset values: new_block = 0, round = 0, ready = 1, sboxw = 0, FSM = IDLE, sword_ctr = 0, latched keylen = 0.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - If next: round_ctr <= 0, ready <= 0, num_rounds <= (keylen ? 14 : 10), go to INIT.
  - Otherwise hold; new_block keeps the last result.
- INIT (round = 0):
  - state <= block ^ round_key.
  - round_ctr <= 1, sword_ctr <= 0, go to SBOX.
- SBOX (4 cycles):
  - sboxw = w[sword_ctr]; only that word is written, with new_sboxw.
  - sword_ctr increments and wraps 3→0.
  - After sword_ctr == 3, go to MAIN.
- MAIN, when round_ctr < num_rounds:
  - state <= mixcolumns(shiftrows(state)) ^ round_key.
  - round_ctr++, sword_ctr <= 0, go to SBOX.
- MAIN, otherwise (final round):
  - state <= shiftrows(state) ^ round_key.
  - ready <= 1, go to IDLE.
  - round_ctr holds num_rounds.
- sboxw = 0 whenever the FSM is not in SBOX.
- ShiftRows is the forward rotation: row r rotates left by r columns, so output word i takes byte r from input word (i+r) mod 4.
- MixColumns per column, GF(2^8) with reduction polynomial 0x11b:
  - mb0 = 2b0^3b1^b2^b3
  - mb1 = b0^2b1^3b2^b3
  - mb2 = b0^b1^2b2^3b3
  - mb3 = 3b0^b1^b2^2b3
- Latency, counted from the clock edge that samples next in IDLE:
  - AES-128: ready is high 52 cycles later (1 + 1 + 10×5).
  - AES-256: ready is high 72 cycles later.
- next while busy: ignored; no restart, no corruption.
- next held high continuously: a new operation starts on the first IDLE cycle after completion.
- keylen changing mid-operation: no effect, because it is latched at acceptance.
- block changing after INIT: no effect.
- reset_n asserted mid-operation: immediate return to the reset values; the partial result is discarded.
- round_key must correspond to `round` in INIT and MAIN; its value is don't-care in other states.

Decomposition:
- aes_pkg holds:
  - AES128_ROUNDS = 10, AES256_ROUNDS = 14.
  - Keylen encodings.
  - FSM state encodings and update-type encodings.
  - Pure functions gm2, gm3, mixw, mixcolumns, shiftrows, addroundkey.
- No internal sub-module. The forward S-box (aes_sbox) is instantiated at core level and muxed between this block and key expansion.

Test Plan:
- FIPS-197 Appendix B: AES-128, key 2b7e1516..09cf4f3c, pt 3243f6a8885a308d313198a2e0370734, round keys served by the bench per `round` → new_block = 3925841d02dc09fbdc118597196a0b32, ready high 52 cycles after next.
- Same vector, S-box timing: first SBOX cycle has sboxw = 193de3be (model returns d42711ae); w0 updates only on that cycle, and sboxw = 0 in INIT and MAIN.
- FIPS-197 C.1 / C.3, pt 00112233445566778899aabbccddeeff:
  - keylen = 0 → 69c4e0d86a7b0430d8cdb78070b4c55a in 52 cycles.
  - keylen = 1 → 8ea2b7ca516745bfeafc49904b496089 in 72 cycles; round reaches 14.
- Busy robustness: pulse next at cycle 20, toggle keylen and block mid-run → the C.1 result is unchanged and no restart occurs (ready low exactly 52 cycles).
- Reset mid-op: assert reset_n low at cycle 30 → new_block = 0, ready = 1, round = 0 at once; a following C.1 run gives the correct ciphertext.
- Back-to-back: next held high for two operations with different plaintexts → each result is correct; ready is high for exactly 1 cycle between the runs.
